// File: rtl/mem3_pkg.sv
// Shared sizing and slot type for the three-slot control-word register memory.
package mem3_pkg;
    localparam int WIDTH       = 3;
    localparam int SLOTS       = 3;
    localparam int SYNC_STAGES = 2;

    typedef logic [WIDTH-1:0] slot_t;
endpackage

// File: rtl/mem3_reg_sync_edge.sv
// Single-bit synchroniser followed by a rising-edge detector on the re-timed signal.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic rise
);
    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], strobe};
            prev <= sync[STAGES-1];
        end
    end

    // prev clears on reset, so a strobe still high after release is seen as a fresh rise
    assign rise = sync[STAGES-1] & ~prev;
endmodule

// File: rtl/mem3_reg.sv
// Three-slot register memory: async strobes and control are re-timed to clk, a strobe rise loads its slot.
module mem3_reg
    import mem3_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       control,
    input  logic [SLOTS-1:0]       strobe,
    output logic [SLOTS*WIDTH-1:0] out,
    output logic [SLOTS-1:0]       wr
);
    slot_t            ctrl_sync [SYNC_STAGES];
    slot_t            slots     [SLOTS];
    logic [SLOTS-1:0] rise;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
            .clk    (clk),
            .rst    (rst),
            .strobe (strobe[i]),
            .rise   (rise[i])
        );
        assign out[i*WIDTH +: WIDTH] = slots[i];
    end

    // Control uses the same depth as the strobes so the word written matches the strobe's sample edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) ctrl_sync[s] <= '0;
        end else begin
            ctrl_sync[0] <= control;
            for (int s = 1; s < SYNC_STAGES; s++) ctrl_sync[s] <= ctrl_sync[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
            wr <= '0;
        end else begin
            wr <= rise;
            for (int i = 0; i < SLOTS; i++) begin
                if (rise[i]) slots[i] <= ctrl_sync[SYNC_STAGES-1];
            end
        end
    end
endmodule

// File: tb/tb_mem3_reg.sv
// Bench for mem3_reg: directed scenarios plus randomised async stimulus against a sample-history model.
module tb_mem3_reg;
    import mem3_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [WIDTH-1:0]       control = '0;
    logic [SLOTS-1:0]       strobe = '0;
    logic [SLOTS*WIDTH-1:0] out;
    logic [SLOTS-1:0]       wr;

    int n_cmp = 0;
    int n_bad = 0;

    mem3_reg dut (
        .clk     (clk),
        .rst     (rst),
        .control (control),
        .strobe  (strobe),
        .out     (out),
        .wr      (wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: remember what each clock edge sampled; a slot loads SYNC_STAGES edges after
    // its strobe was first seen high, using the control value seen at that same edge.
    localparam int D = SYNC_STAGES + 1;
    logic [SLOTS-1:0] h_str [1:D];
    logic [WIDTH-1:0] h_ctl [1:D];
    logic [WIDTH-1:0] m_slot [SLOTS];
    logic [SLOTS-1:0] m_wr;

    initial begin
        for (int k = 1; k <= D; k++) begin h_str[k] = '0; h_ctl[k] = '0; end
        for (int i = 0; i < SLOTS; i++) m_slot[i] = '0;
        m_wr = '0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= D; k++) begin h_str[k] = '0; h_ctl[k] = '0; end
            for (int i = 0; i < SLOTS; i++) m_slot[i] = '0;
            m_wr = '0;
        end else begin
            m_wr = h_str[SYNC_STAGES] & ~h_str[D];
            for (int i = 0; i < SLOTS; i++)
                if (m_wr[i]) m_slot[i] = h_ctl[SYNC_STAGES];
            for (int k = D; k > 1; k--) begin h_str[k] = h_str[k-1]; h_ctl[k] = h_ctl[k-1]; end
            h_str[1] = strobe;
            h_ctl[1] = control;
        end
    end

    function automatic logic [SLOTS*WIDTH-1:0] model_out();
        logic [SLOTS*WIDTH-1:0] v;
        for (int i = 0; i < SLOTS; i++) v[i*WIDTH +: WIDTH] = m_slot[i];
        return v;
    endfunction

    always @(negedge clk) begin
        check("sb_out", 32'(out), 32'(model_out()));
        check("sb_wr", 32'(wr), 32'(m_wr));
    end

    bit rand_on = 0;
    bit done = 0;

    // Strobe and control wander on independent, non-edge-aligned schedules
    initial begin
        wait (rand_on);
        while (!done) begin
            @(posedge clk);
            #($urandom_range(1, 9));
            if ($urandom_range(0, 2) == 0) strobe[$urandom_range(0, SLOTS-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                #1 strobe ^= SLOTS'($urandom_range(1, 7));
            end
        end
    end

    initial begin
        wait (rand_on);
        while (!done) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #($urandom_range(1, 9));
            control = WIDTH'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                #($urandom_range(3, 17));
                rst = 1'b0;
            end
        end
    end

    initial begin
        // 1: reset holds everything at zero despite active inputs
        rst = 1'b1; strobe = 3'b111; control = 3'b101;
        repeat (4) begin
            @(negedge clk);
            check("rst_out", 32'(out), 32'h0);
            check("rst_wr", 32'(wr), 32'h0);
        end
        strobe = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_out", 32'(out), 32'h0);

        // 2: single-slot write lands SYNC_STAGES edges after the first sample
        control = 3'b110; strobe = 3'b001;
        repeat (SYNC_STAGES) begin
            @(negedge clk);
            check("lat_wr", 32'(wr), 32'h0);
        end
        @(negedge clk);
        check("w0_out", 32'(out), 32'h006);
        check("w0_wr", 32'(wr), 32'h1);
        @(negedge clk);
        check("w0_pulse", 32'(wr), 32'h0);

        // 3: held strobe never rewrites
        for (int c = 0; c < 10; c++) begin
            control = WIDTH'(c);
            @(negedge clk);
            check("hold_wr", 32'(wr), 32'h0);
            check("hold_out", 32'(out), 32'h006);
        end

        // 4: simultaneous rises share one control word
        control = 3'b011; strobe = 3'b111;
        repeat (SYNC_STAGES) @(negedge clk);
        @(negedge clk);
        check("dual_out", 32'(out), 32'h0DE);
        check("dual_wr", 32'(wr), 32'h6);
        strobe = 3'b000;
        repeat (4) begin
            @(negedge clk);
            check("fall_wr", 32'(wr), 32'h0);
            check("fall_out", 32'(out), 32'h0DE);
        end

        // 5: reset during synchronisation discards the pending write
        control = 3'b111; strobe = 3'b010;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out", 32'(out), 32'h0);
        check("arst_wr", 32'(wr), 32'h0);
        strobe = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_wr", 32'(wr), 32'h0);
            check("post_out", 32'(out), 32'h0);
        end

        // 6: randomised asynchronous traffic, checked by the model every cycle
        rand_on = 1;
        repeat (3000) @(negedge clk);
        done = 1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
